wb_regfile_csr: RTL and testbench

- Destination end of the writeback interface: consumes the GPR write, CSR write, ecall and mret strobes driven by writeback, and serves operand and CSR reads to decode.
- Holds 16x32 GPRs (RV32E; x0 hardwired to zero) and the machine CSRs.
- Includes a 1-bit-per-register busy scoreboard: decode sets a bit at issue, writeback clears it, and decode uses it to detect RAW hazards.

---
 rtl/wb_regfile_csr_pkg.sv | 46 ++++
 rtl/wb_regfile_csr_checker.sv | 12 +
 rtl/wb_regfile_csr_scoreboard.sv | 56 +++++
 rtl/wb_regfile_csr.sv | 160 ++++++++++++++++
 tb/tb_wb_regfile_csr.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_csr_pkg.sv
// Shared CSR map, mstatus layout and write-legalisation helpers for wb_regfile_csr.
package wb_regfile_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  // Never a write target: used to park the write decoder when no write is pending.
  localparam logic [11:0] CSR_NONE      = 12'h000;

  localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_1888;
  localparam logic [31:0] MSTATUS_MPP_M  = 32'h0000_1800;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Only M-mode exists, so MPP is pinned to 2'b11 whatever software writes.
  function automatic logic [31:0] mstatus_legalize(input logic [31:0] wdata);
    mstatus_legalize = (wdata & MSTATUS_WMASK) | MSTATUS_MPP_M;
  endfunction

  function automatic logic [31:0] mepc_align(input logic [31:0] wdata);
    mepc_align = wdata & ~32'h0000_0003;
  endfunction

  function automatic logic csr_is_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: csr_is_writable = 1'b1;
      default:                                      csr_is_writable = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_wr_legal(input logic [11:0] addr, input logic [31:0] wdata);
    case (addr)
      CSR_MSTATUS: csr_wr_legal = mstatus_legalize(wdata);
      CSR_MEPC:    csr_wr_legal = mepc_align(wdata);
      default:     csr_wr_legal = wdata;
    endcase
  endfunction

endpackage

// File: rtl/wb_regfile_csr_checker.sv
// Simulation-only protocol checks on the writeback strobes feeding wb_regfile_csr.
module wb_regfile_csr_checker (
  input logic clock,
  input logic reset,
  input logic wb_ecall,
  input logic wb_mret
);

  // ecall and mret cannot retire in the same cycle.
  a_no_ecall_with_mret: assert property (@(posedge clock) disable iff (reset) !(wb_ecall && wb_mret));

endmodule

// File: rtl/wb_regfile_csr_scoreboard.sv
// Per-GPR busy bits for RAW hazard detection; set at issue, cleared at writeback, set wins.
// WB_REGFILE_BYPASS_EN: a same-cycle clear hides the busy bit from the read ports.
module wb_scoreboard
  import wb_regfile_csr_pkg::*;
#(
  parameter  int NR_REGS = 16,
  localparam int AW      = $clog2(NR_REGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NR_REGS-1:0] busy_q;
  logic [NR_REGS-1:0] busy_d;

  // Next busy state: a new producer (set) outranks a retiring one (clear); x0 never busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NR_REGS; i++) begin
      if (set_en && (set_addr == i[AW-1:0])) begin
        busy_d[i] = 1'b1;
      end else if (clr_en && (clr_addr == i[AW-1:0])) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy-bit state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= {NR_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  assign rs1_busy = busy_q[rs1_addr] & ~(clr_en && (clr_addr == rs1_addr));
  assign rs2_busy = busy_q[rs2_addr] & ~(clr_en && (clr_addr == rs2_addr));
`else
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: rtl/wb_regfile_csr.sv
// RV32E register file, machine CSRs and busy scoreboard at the writeback destination.
// WB_REGFILE_BYPASS_EN: forward same-cycle GPR/CSR writes and scoreboard clears to the read ports.
module wb_regfile_csr
  import wb_regfile_csr_pkg::*;
#(
  parameter  int          NR_REGS       = 16,
  parameter  int          XLEN          = 32,
  parameter  logic [31:0] MVENDORID_VAL = 32'h7973_7978,
  parameter  logic [31:0] MARCHID_VAL   = 32'h015F_DE9C,
  localparam int          AW            = $clog2(NR_REGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_wdata,
  input  logic            wb_csr_wen,
  input  logic [11:0]     wb_csr_addr,
  input  logic [XLEN-1:0] wb_csr_wdata,
  input  logic            wb_ecall,
  input  logic            wb_mret,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  input  logic            issue_valid,
  input  logic            issue_wen,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  localparam logic [AW-1:0] X0 = {AW{1'b0}};

  logic [XLEN-1:0] gpr_q [NR_REGS];
  logic [XLEN-1:0] gpr_d [NR_REGS];
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q,   mtvec_d;
  logic [XLEN-1:0] mepc_q,    mepc_d;
  logic [XLEN-1:0] mcause_q,  mcause_d;
  logic [XLEN-1:0] rs1_reg, rs2_reg, csr_rd_reg;

  // GPR next state: one write port, x0 never written.
  always_comb begin
    for (int i = 0; i < NR_REGS; i++) begin
      gpr_d[i] = (wb_wen && (wb_rd_addr == i[AW-1:0]) && (i != 0)) ? wb_rd_wdata : gpr_q[i];
    end
  end

  // GPR state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpr_q <= '{default: {XLEN{1'b0}}};
    end else begin
      gpr_q <= gpr_d;
    end
  end

  assign rs1_reg = (rs1_addr == X0) ? {XLEN{1'b0}} : gpr_q[rs1_addr];
  assign rs2_reg = (rs2_addr == X0) ? {XLEN{1'b0}} : gpr_q[rs2_addr];

`ifdef WB_REGFILE_BYPASS_EN
  logic rs1_fwd, rs2_fwd, csr_fwd;
  assign rs1_fwd   = wb_wen && (wb_rd_addr == rs1_addr) && (rs1_addr != X0);
  assign rs2_fwd   = wb_wen && (wb_rd_addr == rs2_addr) && (rs2_addr != X0);
  assign rs1_data  = rs1_fwd ? wb_rd_wdata : rs1_reg;
  assign rs2_data  = rs2_fwd ? wb_rd_wdata : rs2_reg;
  assign csr_fwd   = wb_csr_wen && (wb_csr_addr == csr_raddr) && csr_is_writable(csr_raddr);
  assign csr_rdata = csr_fwd ? csr_wr_legal(csr_raddr, wb_csr_wdata) : csr_rd_reg;
`else
  assign rs1_data  = rs1_reg;
  assign rs2_data  = rs2_reg;
  assign csr_rdata = csr_rd_reg;
`endif

  // CSR next state: software write first, then ecall/mret override the fields they own.
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    case (wb_csr_wen ? wb_csr_addr : CSR_NONE)
      CSR_MSTATUS: mstatus_d = mstatus_legalize(wb_csr_wdata);
      CSR_MTVEC:   mtvec_d   = wb_csr_wdata;
      CSR_MEPC:    mepc_d    = mepc_align(wb_csr_wdata);
      CSR_MCAUSE:  mcause_d  = wb_csr_wdata;
      default:     mtvec_d   = mtvec_q;
    endcase
    if (wb_ecall) begin
      mepc_d                  = mepc_align(wb_pc);
      mcause_d                = MCAUSE_ECALL_M;
      mstatus_d               = mstatus_q;
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
    end else if (wb_mret) begin
      mstatus_d               = mstatus_q;
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end else begin
      mcause_d = mcause_d;
    end
  end

  // CSR state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_q <= MSTATUS_MPP_M;
      mtvec_q   <= {XLEN{1'b0}};
      mepc_q    <= {XLEN{1'b0}};
      mcause_q  <= {XLEN{1'b0}};
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // CSR read mux; unmapped addresses read as zero.
  always_comb begin
    case (csr_raddr)
      CSR_MSTATUS:   csr_rd_reg = mstatus_q;
      CSR_MTVEC:     csr_rd_reg = mtvec_q;
      CSR_MEPC:      csr_rd_reg = mepc_q;
      CSR_MCAUSE:    csr_rd_reg = mcause_q;
      CSR_MVENDORID: csr_rd_reg = MVENDORID_VAL;
      CSR_MARCHID:   csr_rd_reg = MARCHID_VAL;
      default:       csr_rd_reg = {XLEN{1'b0}};
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

  wb_scoreboard #(.NR_REGS(NR_REGS)) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (issue_valid && issue_wen),
    .set_addr (issue_rd),
    .clr_en   (wb_wen),
    .clr_addr (wb_rd_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  wb_regfile_csr_checker u_checker (
    .clock    (clock),
    .reset    (reset),
    .wb_ecall (wb_ecall),
    .wb_mret  (wb_mret)
  );

endmodule

// File: tb/tb_wb_regfile_csr.sv
// Scoreboard-driven bench for wb_regfile_csr: expectations queued at drive time, popped at sample.
module tb_wb_regfile_csr;

  logic        clock, reset;
  logic        wb_wen, wb_csr_wen, wb_ecall, wb_mret;
  logic [3:0]  wb_rd_addr, rs1_addr, rs2_addr, issue_rd;
  logic [31:0] wb_rd_wdata, wb_csr_wdata, wb_pc;
  logic [11:0] wb_csr_addr, csr_raddr;
  logic [31:0] rs1_data, rs2_data, csr_rdata, mtvec_o, mepc_o;
  logic        issue_valid, issue_wen, rs1_busy, rs2_busy;

  logic [31:0] exp_q [$];
  logic [31:0] exp;
  logic [31:0] model [16];
  int          errors = 0;
  int          checks = 0;

  wb_regfile_csr dut (
    .clock(clock), .reset(reset),
    .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_csr_wen(wb_csr_wen), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
    .wb_ecall(wb_ecall), .wb_mret(wb_mret), .wb_pc(wb_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_idle();
    wb_wen = 1'b0; wb_csr_wen = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0;
    issue_valid = 1'b0; issue_wen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_idle();
    wb_rd_addr = 4'd0; wb_rd_wdata = 32'd0; wb_csr_addr = 12'd0; wb_csr_wdata = 32'd0;
    wb_pc = 32'd0; rs1_addr = 4'd0; rs2_addr = 4'd0; csr_raddr = 12'd0; issue_rd = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = i[3:0]; rs2_addr = 4'd15 - i[3:0];
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (rs1_data !== exp) begin errors++; $display("FAIL reset_rs1 x%0d: got %h want %h", i, rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if (rs2_data !== exp) begin errors++; $display("FAIL reset_rs2 x%0d: got %h want %h", 15 - i, rs2_data, exp); end
    end
    csr_raddr = 12'h300; exp_q.push_back(32'h0000_1800); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL reset_mstatus: got %h want %h", csr_rdata, exp); end
    csr_raddr = 12'h342; exp_q.push_back(32'd0); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL reset_mcause: got %h want %h", csr_rdata, exp); end
    checks++;
    if (mtvec_o !== 32'd0 || mepc_o !== 32'd0) begin
      errors++; $display("FAIL reset_vec: got mtvec=%h mepc=%h want 0/0", mtvec_o, mepc_o);
    end
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b%b want 00", rs1_busy, rs2_busy);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_gpr_write();
    @(negedge clock);
    wb_wen = 1'b1; wb_rd_addr = 4'd5; wb_rd_wdata = 32'hDEAD_BEEF;
    model[5] = 32'hDEAD_BEEF; exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clock);
    wb_wen = 1'b0; rs1_addr = 4'd5; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin errors++; $display("FAIL gpr_x5: got %h want %h", rs1_data, exp); end
    @(negedge clock);
    wb_wen = 1'b1; wb_rd_addr = 4'd0; wb_rd_wdata = 32'h0000_1234; exp_q.push_back(32'd0);
    @(negedge clock);
    wb_wen = 1'b0; rs2_addr = 4'd0; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin errors++; $display("FAIL gpr_x0: got %h want %h", rs2_data, exp); end
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      wb_wen = 1'b1; wb_rd_addr = i[3:0]; wb_rd_wdata = $urandom;
      model[i] = wb_rd_wdata; exp_q.push_back(wb_rd_wdata);
    end
    @(negedge clock); wb_wen = 1'b0;
    for (int i = 1; i < 16; i++) begin
      rs2_addr = i[3:0]; #1;
      exp = exp_q.pop_front(); checks++;
      if (rs2_data !== exp) begin errors++; $display("FAIL gpr_sweep x%0d: got %h want %h", i, rs2_data, exp); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      wb_wen = 1'b0;
      if (i <= 4) begin
        wb_wen = 1'b1; wb_rd_addr = i[3:0]; wb_rd_wdata = 32'h1000_0000 + i;
        model[i] = wb_rd_wdata; exp_q.push_back(wb_rd_wdata);
      end
      if (i >= 2) begin
        rs1_addr = i[3:0] - 4'd1; #1;
        exp = exp_q.pop_front(); checks++;
        if (rs1_data !== exp) begin errors++; $display("FAIL b2b x%0d: got %h want %h", i - 1, rs1_data, exp); end
      end
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clock);
    wb_wen = 1'b1; wb_rd_addr = 4'd7; wb_rd_wdata = 32'hA5A5_A5A5; rs1_addr = 4'd7;
`ifdef WB_REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5A5_A5A5);
`else
    exp_q.push_back(model[7]);
`endif
    model[7] = 32'hA5A5_A5A5; exp_q.push_back(32'hA5A5_A5A5);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin errors++; $display("FAIL same_cycle_x7: got %h want %h", rs1_data, exp); end
    @(negedge clock);
    wb_wen = 1'b0; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin errors++; $display("FAIL next_cycle_x7: got %h want %h", rs1_data, exp); end
  endtask

  task automatic test_csr();
    logic [11:0] addrs [7] = '{12'h305, 12'h341, 12'h342, 12'h300, 12'h300, 12'h123, 12'hF11};
    logic [31:0] wdat  [7] = '{32'h0000_1234, 32'h8000_0003, 32'h0000_0005, 32'hFFFF_FFFF,
                               32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] rexp  [7] = '{32'h0000_1234, 32'h8000_0000, 32'h0000_0005, 32'h0000_1888,
                               32'h0000_1800, 32'h0000_0000, 32'h7973_7978};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      wb_csr_wen = 1'b1; wb_csr_addr = addrs[i]; wb_csr_wdata = wdat[i]; exp_q.push_back(rexp[i]);
      @(negedge clock);
      wb_csr_wen = 1'b0; csr_raddr = addrs[i]; #1;
      exp = exp_q.pop_front(); checks++;
      if (csr_rdata !== exp) begin errors++; $display("FAIL csr_%h: got %h want %h", addrs[i], csr_rdata, exp); end
    end
    checks++;
    if (mtvec_o !== 32'h0000_1234 || mepc_o !== 32'h8000_0000) begin
      errors++; $display("FAIL csr_ports: got mtvec=%h mepc=%h want 00001234/80000000", mtvec_o, mepc_o);
    end
  endtask

  task automatic test_ecall_mret();
    @(negedge clock);
    wb_csr_wen = 1'b1; wb_csr_addr = 12'h300; wb_csr_wdata = 32'h0000_0008; exp_q.push_back(32'h0000_1808);
    @(negedge clock);
    wb_csr_wen = 1'b0; csr_raddr = 12'h300; #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL mie_set: got %h want %h", csr_rdata, exp); end
    @(negedge clock);
    wb_ecall = 1'b1; wb_pc = 32'h8000_0010;
    wb_csr_wen = 1'b1; wb_csr_addr = 12'h341; wb_csr_wdata = 32'h0000_0001;
    exp_q.push_back(32'h8000_0010); exp_q.push_back(32'd11); exp_q.push_back(32'h0000_1880);
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (mepc_o !== exp) begin errors++; $display("FAIL ecall_mepc: got %h want %h", mepc_o, exp); end
    csr_raddr = 12'h342; #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL ecall_mcause: got %h want %h", csr_rdata, exp); end
    csr_raddr = 12'h300; #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL ecall_mstatus: got %h want %h", csr_rdata, exp); end
    // mret alongside an mstatus write: the write is dropped
    @(negedge clock);
    wb_mret = 1'b1; wb_csr_wen = 1'b1; wb_csr_addr = 12'h300; wb_csr_wdata = 32'h0000_0000;
    exp_q.push_back(32'h0000_1888);
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL mret_mstatus: got %h want %h", csr_rdata, exp); end
    @(negedge clock);
    wb_ecall = 1'b1; wb_pc = 32'h0000_0400;
    wb_csr_wen = 1'b1; wb_csr_addr = 12'h300; wb_csr_wdata = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0000_1880);
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL ecall_over_mstatus: got %h want %h", csr_rdata, exp); end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd3; exp_q.push_back(32'd1);
    @(negedge clock);
    drive_idle(); rs1_addr = 4'd3; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_busy !== exp[0]) begin errors++; $display("FAIL sb_issue: got %b want %b", rs1_busy, exp[0]); end
    wb_wen = 1'b1; wb_rd_addr = 4'd3; wb_rd_wdata = 32'h0000_3333; model[3] = 32'h0000_3333;
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd3; exp_q.push_back(32'd1);
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_busy !== exp[0]) begin errors++; $display("FAIL sb_set_wins: got %b want %b", rs1_busy, exp[0]); end
    wb_wen = 1'b1; wb_rd_addr = 4'd3;
`ifdef WB_REGFILE_BYPASS_EN
    exp_q.push_back(32'd0);
`else
    exp_q.push_back(32'd1);
`endif
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_busy !== exp[0]) begin errors++; $display("FAIL sb_same_cycle_clr: got %b want %b", rs1_busy, exp[0]); end
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_busy !== exp[0]) begin errors++; $display("FAIL sb_clear: got %b want %b", rs1_busy, exp[0]); end
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd0; exp_q.push_back(32'd0);
    @(negedge clock);
    issue_rd = 4'd9; rs1_addr = 4'd0; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs1_busy !== exp[0]) begin errors++; $display("FAIL sb_x0: got %b want %b", rs1_busy, exp[0]); end
    exp_q.push_back(32'd1);
    @(negedge clock);
    drive_idle(); rs2_addr = 4'd9; #1;
    exp = exp_q.pop_front(); checks++;
    if (rs2_busy !== exp[0]) begin errors++; $display("FAIL sb_x9: got %b want %b", rs2_busy, exp[0]); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clock);
    wb_wen = 1'b1; wb_rd_addr = 4'd6; wb_rd_wdata = 32'h1111_1111;
    wb_csr_wen = 1'b1; wb_csr_addr = 12'h305; wb_csr_wdata = 32'h0000_ABC0;
    @(negedge clock);
    drive_idle(); #2;
    reset = 1'b1; #1;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    for (int i = 1; i < 16; i++) begin
      rs1_addr = i[3:0]; exp_q.push_back(model[i]); #1;
      exp = exp_q.pop_front(); checks++;
      if (rs1_data !== exp) begin errors++; $display("FAIL rst_mid_x%0d: got %h want %h", i, rs1_data, exp); end
    end
    rs2_addr = 4'd9; csr_raddr = 12'h300; #1;
    checks++;
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", rs2_busy); end
    checks++;
    if (csr_rdata !== 32'h0000_1800 || mtvec_o !== 32'd0) begin
      errors++; $display("FAIL rst_mid_csr: got mstatus=%h mtvec=%h want 00001800/0", csr_rdata, mtvec_o);
    end
    @(negedge clock); reset = 1'b0;
    csr_raddr = 12'hF12; exp_q.push_back(32'h015F_DE9C); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL marchid: got %h want %h", csr_rdata, exp); end
    @(negedge clock);
    wb_csr_wen = 1'b1; wb_csr_addr = 12'hF12; wb_csr_wdata = 32'hFFFF_0000; exp_q.push_back(32'h015F_DE9C);
    @(negedge clock);
    drive_idle(); #1;
    exp = exp_q.pop_front(); checks++;
    if (csr_rdata !== exp) begin errors++; $display("FAIL marchid_ro: got %h want %h", csr_rdata, exp); end
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_back_to_back();
    test_same_cycle();
    test_csr();
    test_ecall_mret();
    test_scoreboard();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
